// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel packer: FSM state encoding,
// buffer geometry, status-word bit positions and two small helpers used
// by the packer datapath.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // waiting for a frame start
    ST_CAPTURE = 2'd1,  // packing bytes into words and pushing them
    ST_FULL    = 2'd2   // buffer full, bytes only flag overflow
  } cam_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BUF_WORDS      = 2048;

  // Status word layout: {ovf, busy, 2'b0, wcnt[11:0], frame_cnt[15:0]}
  localparam int unsigned STAT_OVF_BIT   = 31;
  localparam int unsigned STAT_BUSY_BIT  = 30;
  localparam int unsigned STAT_WCNT_LSB  = 16;
  localparam int unsigned STAT_WCNT_W    = 12;
  localparam int unsigned STAT_FCNT_W    = 16;

  function automatic logic [31:0] pack_status(
    input logic                   ovf,
    input logic                   busy,
    input logic [STAT_WCNT_W-1:0] wcnt,
    input logic [STAT_FCNT_W-1:0] fcnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_OVF_BIT]                     = ovf;
    s[STAT_BUSY_BIT]                    = busy;
    s[STAT_WCNT_LSB +: STAT_WCNT_W]     = wcnt;
    s[STAT_FCNT_W-1:0]                  = fcnt;
    return s;
  endfunction

  // Byte lane (lane 0 = bits [7:0]) taken by the idx-th byte of a word.
  function automatic logic [1:0] byte_lane(input logic [1:0] idx, input logic msb_first);
    return msb_first ? (2'(BYTES_PER_WORD - 1) - idx) : idx;
  endfunction

endpackage

// File: rtl/cam_edge_sync.sv
// Oversampling front end for the parallel camera bus.
// All camera inputs (PCLK, VSYNC, HREF, data) travel together through a
// STAGES-deep synchronizer, then one alignment flop. Edge flags for PCLK
// and VSYNC are registered so they line up with the aligned bus outputs.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   pclk_i, vsync_i,  raw asynchronous camera inputs
//   href_i, dat_i
//   pclk_rise_o       one-cycle pulse on a synchronized PCLK rising edge
//   vs_rise_o/fall_o  one-cycle pulses on synchronized VSYNC edges
//   vs_o, href_o,     synchronized levels / data aligned with the pulses
//   dat_o
module cam_edge_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pclk_i,
  input  logic          vsync_i,
  input  logic          href_i,
  input  logic [DW-1:0] dat_i,
  output logic          pclk_rise_o,
  output logic          vs_rise_o,
  output logic          vs_fall_o,
  output logic          vs_o,
  output logic          href_o,
  output logic [DW-1:0] dat_o
);

  localparam int unsigned W        = DW + 3;
  localparam int unsigned PCLK_BIT = W - 1;
  localparam int unsigned VS_BIT   = W - 2;
  localparam int unsigned HREF_BIT = W - 3;

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];
  logic [W-1:0] align_q, align_d;
  logic         pclk_rise_q, pclk_rise_d;
  logic         vs_rise_q, vs_rise_d;
  logic         vs_fall_q, vs_fall_d;

  // NOTE: every signal assigned in an always_comb gets a value on every
  // path (here unconditionally); a missed path would infer a latch.
  always_comb begin
    sync_d[0] = {pclk_i, vsync_i, href_i, dat_i};
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    align_d = sync_q[STAGES-1];
    // Compare the last sync stage against the aligned copy: the pulse is
    // registered in the same edge that moves the new level into align_q,
    // so the flags and the aligned bus describe the same sample.
    pclk_rise_d = sync_q[STAGES-1][PCLK_BIT] & ~align_q[PCLK_BIT];
    vs_rise_d   = sync_q[STAGES-1][VS_BIT]   & ~align_q[VS_BIT];
    vs_fall_d   = ~sync_q[STAGES-1][VS_BIT]  &  align_q[VS_BIT];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      align_q     <= '0;
      pclk_rise_q <= 1'b0;
      vs_rise_q   <= 1'b0;
      vs_fall_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      align_q     <= align_d;
      pclk_rise_q <= pclk_rise_d;
      vs_rise_q   <= vs_rise_d;
      vs_fall_q   <= vs_fall_d;
    end
  end

  assign pclk_rise_o = pclk_rise_q;
  assign vs_rise_o   = vs_rise_q;
  assign vs_fall_o   = vs_fall_q;
  assign vs_o        = align_q[VS_BIT];
  assign href_o      = align_q[HREF_BIT];
  assign dat_o       = align_q[DW-1:0];

endmodule

// File: rtl/cam_pixel_packer.sv
// Camera front-end stage: qualifies camera bytes by frame/line valid,
// packs four bytes per word and pushes each word into the 2048-word frame
// buffer (address bits [10:9] select the bank). Partial words at frame end
// are flushed zero-padded. Frame count, fill level, busy and a sticky
// overflow flag are exported as a status word.
//
// Ports:
//   WBs_CLK_i, WBs_RST_i   clock, synchronous active-high reset
//   PCLKI, VSYNCI, HREFI,  raw camera bus, oversampled in WBs_CLK_i
//   CAM_D_i
//   cap_en_i               capture enable, looked at on frame start only
//   clr_i                  pulse: clear fill count and overflow
//   push_o, push_addr_o,   single-cycle buffer write with held addr/data
//   push_dat_o
//   frame_done_o           pulse at the end of each captured frame
//   status_o               {ovf, busy, 2'b0, wcnt[11:0], frame_cnt[15:0]}
module cam_pixel_packer
  import cam_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 11,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 PCLKI,
  input  logic                 VSYNCI,
  input  logic                 HREFI,
  input  logic [7:0]           CAM_D_i,
  input  logic                 cap_en_i,
  input  logic                 clr_i,
  output logic                 push_o,
  output logic [ADDRWIDTH-1:0] push_addr_o,
  output logic [DATAWIDTH-1:0] push_dat_o,
  output logic                 frame_done_o,
  output logic [31:0]          status_o
);

  localparam logic [ADDRWIDTH:0] WCNT_MAX = (ADDRWIDTH + 1)'(BUF_WORDS);
  localparam logic [1:0]         LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic       pclk_rise, vs_rise, vs_fall, vs_s, href_s;
  logic [7:0] cam_dat_s;
  logic       byte_ok;
  logic [1:0] lane;
  logic       busy;

  cam_state_e           state_q, state_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [DATAWIDTH-1:0] word_q, word_d;
  logic [ADDRWIDTH:0]   wcnt_q, wcnt_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          fcnt_q, fcnt_d;
  logic                 push_q, push_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] dat_q, dat_d;
  logic                 done_q, done_d;

  cam_edge_sync #(
    .STAGES (SYNC_STAGES),
    .DW     (8)
  ) u_sync (
    .clk         (WBs_CLK_i),
    .rst         (WBs_RST_i),
    .pclk_i      (PCLKI),
    .vsync_i     (VSYNCI),
    .href_i      (HREFI),
    .dat_i       (CAM_D_i),
    .pclk_rise_o (pclk_rise),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall),
    .vs_o        (vs_s),
    .href_o      (href_s),
    .dat_o       (cam_dat_s)
  );

  assign byte_ok = pclk_rise & vs_s & href_s;
  assign lane    = byte_lane(byte_idx_q, MSB_FIRST);
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wcnt_d     = wcnt_q;
    ovf_d      = ovf_q;
    fcnt_d     = fcnt_q;
    push_d     = 1'b0;
    addr_d     = addr_q;
    dat_d      = dat_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (vs_rise && cap_en_i) begin
          // A frame that starts with the buffer already full goes straight
          // to FULL so its bytes are flagged instead of pushed.
          state_d    = (wcnt_q == WCNT_MAX) ? ST_FULL : ST_CAPTURE;
          byte_idx_d = '0;
        end
      end

      ST_CAPTURE: begin
        if (byte_ok) begin
          // The first byte of a word clears the other lanes, so a later
          // flush carries zeros in every lane not yet written.
          if (byte_idx_q == '0) begin
            word_d = '0;
          end
          word_d[8*lane +: 8] = cam_dat_s;
          if (byte_idx_q == LAST_IDX) begin
            push_d     = 1'b1;
            addr_d     = wcnt_q[ADDRWIDTH-1:0];
            dat_d      = word_d;
            wcnt_d     = wcnt_q + 1'b1;
            byte_idx_d = '0;
            if (wcnt_d == WCNT_MAX) begin
              state_d = ST_FULL;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (vs_fall) begin
          if (byte_idx_q != '0) begin
            push_d = 1'b1;
            addr_d = wcnt_q[ADDRWIDTH-1:0];
            dat_d  = word_q;
            wcnt_d = wcnt_q + 1'b1;
          end
          byte_idx_d = '0;
          done_d     = 1'b1;
          fcnt_d     = fcnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end

      ST_FULL: begin
        if (byte_ok) begin
          ovf_d = 1'b1;
        end else if (vs_fall) begin
          byte_idx_d = '0;
          done_d     = 1'b1;
          fcnt_d     = fcnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Clear wins over any increment above, but a push decided this cycle
    // still goes out with the address it already latched. Inside a frame
    // the partial word is dropped and packing restarts on a word boundary.
    if (clr_i) begin
      wcnt_d = '0;
      ovf_d  = 1'b0;
      if (state_d != ST_IDLE) begin
        byte_idx_d = '0;
        state_d    = ST_CAPTURE;
      end
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      word_q     <= '0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      fcnt_q     <= '0;
      push_q     <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      fcnt_q     <= fcnt_d;
      push_q     <= push_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
    end
  end

  assign push_o       = push_q;
  assign push_addr_o  = addr_q;
  assign push_dat_o   = dat_q;
  assign frame_done_o = done_q;
  assign status_o     = pack_status(ovf_q, busy, STAT_WCNT_W'(wcnt_q), fcnt_q);

endmodule
